// File: rtl/id_ex_ctrl_pipe.sv
// Main control decoder and ID/EX control pipeline register.
// Decodes opcode/funct in ID and holds, bubbles or captures the controls into EX.
module id_ex_ctrl_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    output logic             ex_valid,
    output logic [1:0]       ex_ALUOp,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,
    output logic             ex_RegDst,
    output logic             ex_ALUSrc,
    output logic             ex_MemtoReg,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_Branch,
    output logic             ex_BranchNe,
    output logic             ex_Jump,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
    } ctrl_t;

    ctrl_t      dec_ctrl;
    logic       dec_legal;
    logic [5:0] dec_funct;

    ctrl_t      ex_ctrl;

    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        dec_funct = 6'h00;
        case (id_opcode)
            6'h00: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_funct          = id_funct;
                case (id_funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h11, 6'h2A, 6'h10: dec_legal = 1'b1;
                    default:                                         dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            6'h23: begin
                dec_ctrl.alu_op     = 2'b10;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
            end
            6'h2B: begin
                dec_ctrl.alu_op    = 2'b10;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            6'h04: begin
                dec_ctrl.alu_op = 2'b01;
                dec_ctrl.branch = 1'b1;
            end
            6'h05: begin
                dec_ctrl.alu_op    = 2'b01;
                dec_ctrl.branch_ne = 1'b1;
            end
            6'h02:   dec_ctrl.jump = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Priority: flush > stall > no instruction > illegal > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl     <= '0;
            ex_valid    <= 1'b0;
            ex_opcode   <= 6'h00;
            ex_funct    <= 6'h00;
            ex_illegal  <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            ex_ctrl    <= '0;
            ex_valid   <= 1'b0;
            ex_opcode  <= 6'h00;
            ex_funct   <= 6'h00;
            ex_illegal <= 1'b0;
        end else if (stall) begin
            ex_illegal <= 1'b0;
        end else if (!id_valid || !dec_legal) begin
            ex_ctrl    <= '0;
            ex_valid   <= 1'b0;
            ex_opcode  <= 6'h00;
            ex_funct   <= 6'h00;
            ex_illegal <= id_valid;
            if (id_valid && (illegal_cnt != {CNT_W{1'b1}})) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end else begin
            ex_ctrl    <= dec_ctrl;
            ex_valid   <= 1'b1;
            ex_opcode  <= id_opcode;
            ex_funct   <= dec_funct;
            ex_illegal <= 1'b0;
        end
    end

    assign ex_ALUOp    = ex_ctrl.alu_op;
    assign ex_RegDst   = ex_ctrl.reg_dst;
    assign ex_ALUSrc   = ex_ctrl.alu_src;
    assign ex_MemtoReg = ex_ctrl.mem_to_reg;
    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_Branch   = ex_ctrl.branch;
    assign ex_BranchNe = ex_ctrl.branch_ne;
    assign ex_Jump     = ex_ctrl.jump;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: directed steps then random traffic against a rule-based model,
// with an 8-bit and a 2-bit counter instance driven in parallel.
module tb_id_ex_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, stall, flush;
    logic [5:0] id_opcode, id_funct;

    logic       ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
    logic       ex_MemRead, ex_MemWrite, ex_Branch, ex_BranchNe, ex_Jump, ex_illegal;
    logic [1:0] ex_ALUOp;
    logic [5:0] ex_opcode, ex_funct;
    logic [7:0] illegal_cnt;

    logic       c2_valid, c2_RegDst, c2_ALUSrc, c2_MemtoReg, c2_RegWrite;
    logic       c2_MemRead, c2_MemWrite, c2_Branch, c2_BranchNe, c2_Jump, c2_illegal;
    logic [1:0] c2_ALUOp;
    logic [5:0] c2_opcode, c2_funct;
    logic [1:0] c2_cnt;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_ctrl;
    logic        m_ill;
    int          m_cnt8, m_cnt2;

    logic [5:0] legal_ops[10]  = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [5:0] legal_fns[7]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h11, 6'h2A, 6'h10};

    always #5 clk = ~clk;

    id_ex_ctrl_pipe #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_BranchNe(ex_BranchNe), .ex_Jump(ex_Jump),
        .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
    );

    id_ex_ctrl_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .ex_valid(c2_valid), .ex_ALUOp(c2_ALUOp), .ex_opcode(c2_opcode), .ex_funct(c2_funct),
        .ex_RegDst(c2_RegDst), .ex_ALUSrc(c2_ALUSrc), .ex_MemtoReg(c2_MemtoReg),
        .ex_RegWrite(c2_RegWrite), .ex_MemRead(c2_MemRead), .ex_MemWrite(c2_MemWrite),
        .ex_Branch(c2_Branch), .ex_BranchNe(c2_BranchNe), .ex_Jump(c2_Jump),
        .ex_illegal(c2_illegal), .illegal_cnt(c2_cnt)
    );

    wire [23:0] act8 = {ex_valid, ex_ALUOp, ex_opcode, ex_funct, ex_RegDst, ex_ALUSrc,
                        ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
                        ex_BranchNe, ex_Jump};
    wire [23:0] act2 = {c2_valid, c2_ALUOp, c2_opcode, c2_funct, c2_RegDst, c2_ALUSrc,
                        c2_MemtoReg, c2_RegWrite, c2_MemRead, c2_MemWrite, c2_Branch,
                        c2_BranchNe, c2_Jump};

    // Expected EX vector from the instruction-class rules of the decode table.
    function automatic logic [23:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                               output logic legal);
        logic is_r, r_ok, is_imm, is_lw, is_sw, is_br, is_j;
        logic [1:0] aluop;
        is_r   = (op == 6'h00);
        r_ok   = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h11, 6'h2A, 6'h10};
        is_imm = op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_br  = (op == 6'h04) || (op == 6'h05);
        is_j   = (op == 6'h02);
        legal  = (is_r && r_ok) || is_imm || is_lw || is_sw || is_br || is_j;
        aluop  = (is_lw || is_sw) ? 2'b10 : (is_br ? 2'b01 : 2'b00);
        return {1'b1, aluop, op, (is_r ? fn : 6'h00), is_r, (is_imm || is_lw || is_sw),
                is_lw, (is_r || is_imm || is_lw), is_lw, is_sw, (op == 6'h04),
                (op == 6'h05), is_j};
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_ill = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        logic        legal;
        logic [23:0] d;
        d = ref_decode(id_opcode, id_funct, legal);
        m_ill = 1'b0;
        if (flush)          m_ctrl = '0;
        else if (stall)     m_ctrl = m_ctrl;
        else if (!id_valid) m_ctrl = '0;
        else if (!legal) begin
            m_ctrl = '0;
            m_ill  = 1'b1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end else            m_ctrl = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_ctrl"},   32'(act8),        32'(m_ctrl));
        check({tag, "_ill"},    32'(ex_illegal),  32'(m_ill));
        check({tag, "_cnt"},    32'(illegal_cnt), 32'(m_cnt8));
        check({tag, "_ctrl2"},  32'(act2),        32'(m_ctrl));
        check({tag, "_ill2"},   32'(c2_illegal),  32'(m_ill));
        check({tag, "_cnt2"},   32'(c2_cnt),      32'(m_cnt2));
    endtask

    task automatic step(input string tag, input logic v, input logic s, input logic f,
                        input logic [5:0] op, input logic [5:0] fn);
        id_valid = v; stall = s; flush = f; id_opcode = op; id_funct = fn;
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        id_opcode = 6'h00; id_funct = 6'h00;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // Asynchronous reset mid-stream, checked before the next edge.
        step("sub_pre", 1, 0, 0, 6'h00, 6'h22);
        check("pre_rst_regwrite", 32'(ex_RegWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        step("in_rst", 1, 0, 0, 6'h23, 6'h00);
        rst_n = 1'b1;
        step("post_rst_a", 0, 0, 0, 6'h23, 6'h00);
        step("post_rst_b", 0, 0, 0, 6'h00, 6'h20);

        step("sub", 1, 0, 0, 6'h00, 6'h22);
        check("sub_funct", 32'(ex_funct), 32'h22);
        step("addi", 1, 0, 0, 6'h08, 6'h22);
        check("addi_funct", 32'(ex_funct), 32'h00);
        check("addi_opcode", 32'(ex_opcode), 32'h08);
        step("lw", 1, 0, 0, 6'h23, 6'h15);
        step("sw", 1, 0, 0, 6'h2B, 6'h00);
        check("sw_regwrite", 32'(ex_RegWrite), 32'd0);
        step("bne", 1, 0, 0, 6'h05, 6'h2A);
        check("bne_branch", 32'({ex_Branch, ex_BranchNe, ex_ALUOp}), 32'b0101);
        step("j", 1, 0, 0, 6'h02, 6'h00);

        step("lw2", 1, 0, 0, 6'h23, 6'h00);
        for (int i = 0; i < 3; i++) step("stall_hold", 1, 1, 0, 6'h2B, 6'h00);
        check("stall_memread", 32'(ex_MemRead), 32'd1);
        step("stall_flush", 1, 1, 1, 6'h23, 6'h00);
        check("flush_valid", 32'(ex_valid), 32'd0);

        step("ill_op", 1, 0, 0, 6'h3F, 6'h00);
        check("ill_op_cnt", 32'(illegal_cnt), 32'd1);
        step("ill_gap", 0, 0, 0, 6'h3F, 6'h00);
        step("ill_fn", 1, 0, 0, 6'h00, 6'h3F);
        check("ill_fn_cnt", 32'(illegal_cnt), 32'd2);
        step("addi2", 1, 0, 0, 6'h0C, 6'h00);
        step("ill_stall_a", 1, 1, 0, 6'h3E, 6'h00);
        step("ill_stall_b", 1, 1, 0, 6'h3E, 6'h00);
        step("ill_capt", 1, 0, 0, 6'h3E, 6'h00);
        check("ill_stalled_cnt", 32'(illegal_cnt), 32'd3);
        step("ill_flushed", 1, 1, 1, 6'h3E, 6'h00);

        for (int i = 0; i < 5; i++) step("sat", 1, 0, 0, 6'h01, 6'h00);
        check("sat_cnt2", 32'(c2_cnt), 32'd3);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_fns[$urandom_range(0, 6)];
            step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), op, fn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
